serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 1..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to add a and b; sampled only in IDLE.
REQ-005 a  input  WIDTH  addend A; sampled on the edge that accepts start.
REQ-006 b  input  WIDTH  addend B; sampled on the edge that accepts start.
REQ-007 busy  output  1  high while in RUN.
REQ-008 done  output  1  one-cycle pulse; result valid.
REQ-009 sum  output  WIDTH  result bits, registered.
REQ-010 cout  output  1  carry out of bit WIDTH-1, registered.

Function
REQ-011 Block SHALL add a+b bit-serially, LSB first, one bit per clock, through a single full-adder bit slice.
REQ-012 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 IDLE with start=1 at an edge SHALL latch a and b into shift registers, clear the carry register, clear sum to 0, clear the bit counter to 0, and go to RUN.
REQ-014 IDLE with start=0 SHALL remain in IDLE and hold sum and cout.
REQ-015 Each RUN edge SHALL shift the slice sum bit into sum MSB-first shifting (after WIDTH edges sum[0] holds bit 0), update carry with slice carry, shift operands right by one, and increment the counter.
REQ-016 On the RUN edge where counter = WIDTH-1, FSM SHALL go to DONE and load cout with the final slice carry.
REQ-017 done SHALL be 1 only in DONE, i.e. exactly WIDTH edges after the accepting edge, for one cycle; DONE SHALL go to IDLE on the next edge unconditionally.
REQ-018 busy SHALL be 1 only in RUN; done and busy SHALL never be high together.
REQ-019 start in RUN or DONE SHALL be ignored; no queuing; a, b changes during RUN SHALL not affect the result.
REQ-020 sum and cout SHALL hold the last result from DONE until the next accepted start.
REQ-021 start held continuously high SHALL give one operation per WIDTH+2 cycles (accept, WIDTH-1 further RUN edges, DONE, IDLE accept).
REQ-022 Arithmetic SHALL be unsigned modulo 2^WIDTH with the overflow bit on cout; {cout,sum} SHALL equal a+b exactly.
REQ-023 Counter width SHALL be clog2(WIDTH+1) bits; WIDTH=1 SHALL give RUN for exactly one edge.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE and clear sum, cout, carry, counter, and operand registers to 0, with busy=0 and done=0, overriding start.
REQ-025 rst during RUN or DONE SHALL abort the operation without a done pulse; the first edge with rst=0 and start=1 SHALL accept a new operation.

Structure
REQ-026 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant SHALL live in the shared package adder_pkg.
REQ-027 The bit slice SHALL be a sub-module fa_bit (inputs x, y, cin; outputs s, co), built from two half-adder stages (XOR/AND) plus an OR; the controller instantiates it once.
REQ-028 fa_bit SHALL be purely combinational; all storage SHALL be in serial_adder_ctrl.

Verification
REQ-029 WIDTH=8, a=8'h05, b=8'h03, start pulse -> busy high 8 cycles, done pulse on 8th edge after accept, sum=8'h08, cout=0.
REQ-030 WIDTH=8, a=8'hFF, b=8'h01 -> sum=8'h00, cout=1; values hold through 5 idle cycles.
REQ-031 WIDTH=8, accept 8'h10+8'h20, then pulse start with a=8'hFF,b=8'hFF during RUN -> ignored; result sum=8'h30, cout=0, single done.
REQ-032 WIDTH=8, rst asserted on 4th RUN edge -> next cycle IDLE, sum=0, cout=0, no done; then 8'h7F+8'h01 -> sum=8'h80, cout=0.
REQ-033 WIDTH=8, start held high, operand pairs (1,2),(200,100) -> done pulses 10 cycles apart, results 8'h03/0 then 8'h2C/1.
REQ-034 WIDTH=1, a=1, b=1 -> done one edge after accept, sum=0, cout=1; random-regression check {cout,sum}==a+b over 1000 operations at WIDTH=8.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: shared FSM encoding and default operand width for the serial adder.
package adder_pkg;
   localparam int WIDTH_DEF = 8;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/fa_bit.sv
// fa_bit: combinational full-adder slice built from two half-adder stages and an OR.
module fa_bit (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic co
);
   logic hs, hc, cc;
   assign hs = x ^ y;
   assign hc = x & y;
   assign s  = hs ^ cin;
   assign cc = hs & cin;
   assign co = hc | cc;
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial unsigned adder, LSB first, one bit per clock through one fa_bit.
module serial_adder_ctrl
   import adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH + 1);
   state_t state, nxt;
   logic [WIDTH-1:0] opa, opb;
   logic [CW-1:0] cnt;
   logic carry, s, co, last, accept;
   fa_bit u_fa (.x(opa[0]), .y(opb[0]), .cin(carry), .s(s), .co(co));
   assign last   = cnt == CW'(WIDTH - 1);
   assign accept = state == IDLE && start;
   assign busy   = state == RUN;
   assign done   = state == DONE;
   always_comb begin
      nxt = state;
      if (accept) nxt = RUN;
      else if (state == RUN && last) nxt = DONE;
      else if (state != IDLE && state != RUN) nxt = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         opa   <= '0;
         opb   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         state <= nxt;
         if (accept) begin
            opa   <= a;
            opb   <= b;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
         end else if (state == RUN) begin
            // new bit enters at the MSB so bit 0 lands in sum[0] after WIDTH shifts
            sum   <= (sum >> 1) | (WIDTH'(s) << (WIDTH - 1));
            carry <= co;
            opa   <= opa >> 1;
            opb   <= opb >> 1;
            cnt   <= cnt + CW'(1);
            if (last) cout <= co;
         end
      end
   end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: table vectors, corner sequences and random regression against a+b.
module tb_serial_adder_ctrl;
   logic clk = 1'b0, rst = 1'b1;
   logic start = 1'b0, start1 = 1'b0;
   logic [7:0] a = '0, b = '0, sum;
   logic a1 = 1'b0, b1 = 1'b0, sum1;
   logic busy, done, cout, busy1, done1, cout1;
   int checks = 0, errors = 0;
   int busy_cnt, done_k, overlap;
   logic [7:0] rs;
   logic rc;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] s;
      logic       c;
   } vec_t;
   vec_t vecs[6];

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .sum(sum), .cout(cout));
   serial_adder_ctrl #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // one operation on the 8-bit instance; leaves the bench at the negedge where done is seen
   task automatic run_op(input logic [7:0] x, input logic [7:0] y);
      @(negedge clk);
      a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      busy_cnt = 0; done_k = 0; overlap = 0;
      for (int k = 1; k <= 20 && done_k == 0; k++) begin
         if (busy && done) overlap = 1;
         if (busy) busy_cnt++;
         if (done) begin
            done_k = k; rs = sum; rc = cout;
         end
         if (done_k == 0) @(negedge clk);
      end
      if (done_k == 0) chk("done_timeout", 0, 1);
   endtask

   initial begin
      int d_cnt, t[2];
      logic [7:0] ds[2];
      logic dc[2];
      logic [7:0] x, y;
      vecs[0] = '{8'h05, 8'h03, 8'h08, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
      vecs[2] = '{8'h10, 8'h20, 8'h30, 1'b0};
      vecs[3] = '{8'h7F, 8'h01, 8'h80, 1'b0};
      vecs[4] = '{8'h01, 8'h02, 8'h03, 1'b0};
      vecs[5] = '{8'hC8, 8'h64, 8'h2C, 1'b1};
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_sum", sum, 0);
      chk("reset_cout", cout, 0);
      start = 1'b0; rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         run_op(vecs[i].a, vecs[i].b);
         chk($sformatf("vec%0d_sum", i), rs, vecs[i].s);
         chk($sformatf("vec%0d_cout", i), rc, vecs[i].c);
         chk($sformatf("vec%0d_busy_cycles", i), busy_cnt, 8);
         chk($sformatf("vec%0d_done_edge", i), done_k - 1, 8);
         chk($sformatf("vec%0d_overlap", i), overlap, 0);
      end
      // result holds through idle cycles
      run_op(8'hFF, 8'h01);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_sum", sum, 8'h00);
         chk("hold_cout", cout, 1);
         chk("hold_done", done, 0);
      end
      // start during RUN is ignored
      @(negedge clk);
      a = 8'h10; b = 8'h20; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      a = 8'hFF; b = 8'hFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      d_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (done) begin
            d_cnt++; rs = sum; rc = cout;
         end
         @(negedge clk);
      end
      chk("ignore_done_count", d_cnt, 1);
      chk("ignore_sum", rs, 8'h30);
      chk("ignore_cout", rc, 0);
      // reset on 4th RUN edge aborts
      @(negedge clk);
      a = 8'h55; b = 8'h66; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_sum", sum, 0);
      chk("abort_cout", cout, 0);
      d_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         if (done || busy) d_cnt++;
         @(negedge clk);
      end
      chk("abort_no_done", d_cnt, 0);
      run_op(8'h7F, 8'h01);
      chk("after_abort_sum", rs, 8'h80);
      chk("after_abort_cout", rc, 0);
      // start held high: back-to-back operations
      @(negedge clk);
      a = 8'd1; b = 8'd2; start = 1'b1;
      @(negedge clk);
      a = 8'd200; b = 8'd100;
      d_cnt = 0; t[0] = 0; t[1] = 0;
      for (int k = 0; k < 40 && d_cnt < 2; k++) begin
         if (done) begin
            t[d_cnt] = k; ds[d_cnt] = sum; dc[d_cnt] = cout; d_cnt++;
         end
         if (d_cnt < 2) @(negedge clk);
      end
      start = 1'b0;
      chk("b2b_done_count", d_cnt, 2);
      chk("b2b_spacing", t[1] - t[0], 10);
      chk("b2b_sum0", ds[0], 8'h03);
      chk("b2b_cout0", dc[0], 0);
      chk("b2b_sum1", ds[1], 8'h2C);
      chk("b2b_cout1", dc[1], 1);
      repeat (3) @(negedge clk);
      // WIDTH=1 instance
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         a1 = i[0]; b1 = i[1]; start1 = 1'b1;
         @(negedge clk);
         start1 = 1'b0;
         chk($sformatf("w1_busy%0d", i), busy1, 1);
         @(negedge clk);
         chk($sformatf("w1_done%0d", i), done1, 1);
         chk($sformatf("w1_overlap%0d", i), busy1, 0);
         chk($sformatf("w1_result%0d", i), {cout1, sum1}, 32'(i[0]) + 32'(i[1]));
      end
      // random regression against plain arithmetic
      for (int i = 0; i < 1000; i++) begin
         x = 8'($urandom);
         y = 8'($urandom);
         run_op(x, y);
         chk("rand_result", {rc, rs}, 9'(x) + 9'(y));
         if (busy_cnt != 8 || overlap != 0) chk("rand_timing", busy_cnt, 8);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
